// File: rtl/rpc_defs_pkg.sv
// Shared RPC transport types plus the TX scheduler's state encoding and default sizing.
package rpc_defs;

  typedef struct packed {
    logic [15:0] flow_id;
    logic [47:0] payload;
  } RpcIf;

  typedef enum logic {
    SCHED_IDLE  = 1'b0,
    SCHED_SERVE = 1'b1
  } SchedState_t;

  localparam int RPC_SCHED_N_REQ     = 4;
  localparam int RPC_SCHED_MAX_BURST = 4;

endpackage

// File: rtl/rpc_tx_scheduler_pick.sv
// rr_priority_pick: combinational first-set search starting at a rotating pointer.
module rr_priority_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin : p_pick
    int c;
    idx   = '0;
    found = 1'b0;
    // Walk offsets from far to near so the nearest set bit to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (req[c]) begin
        idx   = IDX_W'(c);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rpc_tx_scheduler.sv
// Round-robin, burst-bounded arbiter feeding the shared RPC serializer.
// Optional per-requester transfer counters under RPC_SCHED_STATS_EN.
module rpc_tx_scheduler
  import rpc_defs::*;
#(
  parameter  int N_REQ     = RPC_SCHED_N_REQ,
  parameter  int MAX_BURST = RPC_SCHED_MAX_BURST,
  parameter  int NIC_ID    = 0,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  RpcIf [N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       cfg_req_en,
  input  logic                   net_tx_ready,
  output logic                   rpc_valid_out,
  output RpcIf                   rpc_out,
  output logic [IDX_W-1:0]       cur_grant,
  output logic                   busy
`ifdef RPC_SCHED_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [N_REQ-1:0][31:0] stat_tx_cnt
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);

  if (N_REQ < 2 || MAX_BURST < 1 || NIC_ID < 0) begin : g_bad_param
    $error("rpc_tx_scheduler: illegal parameter set");
  end

  SchedState_t      state, state_nxt;
  logic [IDX_W-1:0] cur, cur_nxt, rr_ptr, rr_nxt, pick_idx;
  logic [BW-1:0]    burst_cnt, burst_nxt;
  logic [N_REQ-1:0] eligible;
  logic             pick_found, xfer;

  assign eligible  = req_valid & cfg_req_en;
  assign busy      = (state == SCHED_SERVE);
  assign cur_grant = cur;

  rr_priority_pick #(.N(N_REQ)) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    rr_nxt    = rr_ptr;
    burst_nxt = burst_cnt;
    req_ready = '0;
    xfer      = 1'b0;
    case (state)
      SCHED_IDLE: begin
        if (pick_found && net_tx_ready) begin
          cur_nxt   = pick_idx;
          burst_nxt = '0;
          state_nxt = SCHED_SERVE;
        end
      end
      SCHED_SERVE: begin
        // Enable drop on the granted port masks ready in the same cycle.
        req_ready[cur] = net_tx_ready & cfg_req_en[cur];
        xfer           = req_valid[cur] & req_ready[cur];
        if (xfer) burst_nxt = burst_cnt + 1'b1;
        if ((xfer && burst_cnt == BW'(MAX_BURST - 1)) || !req_valid[cur] || !cfg_req_en[cur]) begin
          state_nxt = SCHED_IDLE;
          rr_nxt    = (cur == IDX_W'(N_REQ - 1)) ? '0 : cur + 1'b1;
        end
      end
      default: state_nxt = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SCHED_IDLE;
      cur           <= '0;
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      rpc_valid_out <= 1'b0;
      rpc_out       <= '0;
    end else begin
      state         <= state_nxt;
      cur           <= cur_nxt;
      rr_ptr        <= rr_nxt;
      burst_cnt     <= burst_nxt;
      rpc_valid_out <= xfer;
      rpc_out       <= xfer ? req_data[cur] : '0;
    end
  end

`ifdef RPC_SCHED_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic hit;
    assign hit = xfer && (cur == IDX_W'(i));
    always_ff @(posedge clk) begin
      if (reset)         stat_tx_cnt[i] <= '0;
      else if (stat_clr) stat_tx_cnt[i] <= {31'd0, hit};
      else if (hit)      stat_tx_cnt[i] <= stat_tx_cnt[i] + 32'd1;
    end
  end
`endif

endmodule
